// File: rtl/audio_pll_lock_sequencer_if.sv
// Control and status bundle between the audio PLL lock sequencer and its environment.
interface audio_pll_lock_sequencer_if;
  logic       enable;
  logic       pll_locked;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic       lol_pulse;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  // Handshake: enable is a level request held by the master for as long as the PLL should
  // run; ready is a level status (not a per-transfer ready), true only while the clock is usable.
  modport master (
    output enable, pll_locked,
    input  pll_rst, ready, fault, lol_pulse, retry_cnt, loss_cnt
  );

  modport slave (
    input  enable, pll_locked,
    output pll_rst, ready, fault, lol_pulse, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/audio_pll_lock_sequencer.sv
// Brings an audio PLL out of reset, waits for a stable lock, retries on timeout and
// reports loss of lock; every output is a register.
module audio_pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  audio_pll_lock_sequencer_if.slave  bus,
  output logic [2:0]                 o_dbg_state
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_locked_s;
  logic [CW-1:0] r_cnt;
  logic          r_pll_rst;
  logic          r_ready;
  logic          r_fault;
  logic          r_lol_pulse;
  logic [3:0]    r_retry_cnt;
  logic [7:0]    r_loss_cnt;

  // pll_locked comes from the PLL's own clock domain; nothing downstream looks at it raw.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= bus.pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_lol_pulse <= 1'b0;
      r_retry_cnt <= 4'd0;
      r_loss_cnt  <= 8'd0;
    end else begin
      r_lol_pulse <= 1'b0;
      if (!bus.enable) begin
        // Dropping enable wins over everything, including a loss of lock in the same cycle.
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_pll_rst <= 1'b1;
        r_ready   <= 1'b0;
        r_fault   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_RESET;
            r_cnt       <= '0;
            r_retry_cnt <= 4'd0;
            r_pll_rst   <= 1'b1;
          end
          S_RESET: begin
            if (r_cnt == RST_LAST) begin
              r_state   <= S_WAIT_LOCK;
              r_cnt     <= '0;
              r_pll_rst <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_WAIT_LOCK: begin
            if (r_locked_s) begin
              r_state <= S_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == TMO_LAST) begin
              r_cnt     <= '0;
              r_pll_rst <= 1'b1;
              if (r_retry_cnt < RETRY_MAX) begin
                r_state     <= S_RESET;
                r_retry_cnt <= r_retry_cnt + 4'd1;
              end else begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_STABLE: begin
            // A lock glitch restarts the wait without spending a retry.
            if (!r_locked_s) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == STB_LAST) begin
              r_state     <= S_RUN;
              r_cnt       <= '0;
              r_ready     <= 1'b1;
              r_retry_cnt <= 4'd0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_RUN: begin
            if (!r_locked_s) begin
              r_state     <= S_RESET;
              r_cnt       <= '0;
              r_pll_rst   <= 1'b1;
              r_ready     <= 1'b0;
              r_lol_pulse <= 1'b1;
              if (r_loss_cnt != 8'hFF) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
              end
            end
          end
          S_FAULT: begin
            r_fault   <= 1'b1;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
          end
          default: begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst   = r_pll_rst;
  assign bus.ready     = r_ready;
  assign bus.fault     = r_fault;
  assign bus.lol_pulse = r_lol_pulse;
  assign bus.retry_cnt = r_retry_cnt;
  assign bus.loss_cnt  = r_loss_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_audio_pll_lock_sequencer.sv
// Self-checking bench for audio_pll_lock_sequencer: timing expectations are derived from
// the sequencer's rules (sync latency, window lengths, retry budget) with plain arithmetic.
module tb_audio_pll_lock_sequencer;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int MAX_RETRIES  = 2;

  localparam int SYNC_LAT     = 2;
  // pll_locked rise -> ready: synchronizer, the WAIT_LOCK decision edge, then the stable window
  localparam int READY_LAT    = SYNC_LAT + 1 + LOCK_STABLE;
  localparam int LOL_LAT      = SYNC_LAT + 1;
  localparam int EN_TO_REL    = 1 + RST_CYCLES;
  localparam int RETRY_PERIOD = RST_CYCLES + LOCK_TIMEOUT;
  localparam int FAULT_LAT    = 1 + (MAX_RETRIES + 1) * RETRY_PERIOD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] dbg_state;

  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_loss = 0;
  logic [7:0] exp_q[$];

  audio_pll_lock_sequencer_if bus();

  audio_pll_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rst_fall(input int budget, output int lat, output bit ok);
    int i = 0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && i < budget) begin
      tick();
      i++;
      if (bus.pll_rst === 1'b0) begin
        ok  = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic wait_ready(input int budget, output int lat, output bit ok, output bit saw_rst);
    int i = 0;
    lat     = 0;
    ok      = 1'b0;
    saw_rst = 1'b0;
    while (!ok && i < budget) begin
      tick();
      i++;
      if (bus.pll_rst === 1'b1) saw_rst = 1'b1;
      if (bus.ready === 1'b1) begin
        ok  = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic wait_lol(input int budget, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < budget) begin
      tick();
      i++;
      if (bus.lol_pulse === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic bring_up(output bit ok);
    int lat;
    bit ok1, ok2, saw;
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    tick();
    tick();
    bus.enable = 1'b1;
    wait_rst_fall(20, lat, ok1);
    bus.pll_locked = 1'b1;
    wait_ready(READY_LAT + 20, lat, ok2, saw);
    ok = ok1 && ok2;
  endtask

  // tests
  task automatic test_reset();
    logic [15:0] got;
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    got = {bus.pll_rst, bus.ready, bus.fault, bus.lol_pulse, bus.retry_cnt, bus.loss_cnt};
    n_checks++;
    if (got !== 16'h8000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 8000", got);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    got = {bus.pll_rst, bus.ready, bus.fault, bus.lol_pulse, bus.retry_cnt, bus.loss_cnt};
    n_checks++;
    if (got !== 16'h8000) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected 8000", got);
    end
  endtask

  task automatic test_nominal();
    int lat, delay;
    bit ok, saw;
    for (int it = 0; it < 4; it++) begin
      delay = (it == 0) ? 10 : int'($urandom_range(0, 25));
      bus.enable     = 1'b0;
      bus.pll_locked = 1'b0;
      tick();
      tick();
      bus.enable = 1'b1;
      wait_rst_fall(20, lat, ok);
      n_checks++;
      if (!ok || lat != EN_TO_REL) begin
        n_fail++;
        $display("FAIL nominal_rst_len[%0d]: got %0d (ok=%0b) expected %0d", it, lat, ok, EN_TO_REL);
      end
      repeat (delay) tick();
      bus.pll_locked = 1'b1;
      wait_ready(READY_LAT + 20, lat, ok, saw);
      n_checks++;
      if (!ok || lat != READY_LAT || saw) begin
        n_fail++;
        $display("FAIL nominal_ready_lat[%0d]: got %0d (ok=%0b rst=%0b) expected %0d", it, lat, ok, saw, READY_LAT);
      end
      n_checks++;
      if (bus.retry_cnt !== 4'd0 || bus.pll_rst !== 1'b0) begin
        n_fail++;
        $display("FAIL nominal_run_state[%0d]: got retry=%0d pll_rst=%b expected 0/0", it, bus.retry_cnt, bus.pll_rst);
      end
    end
  endtask

  task automatic test_glitch();
    int lat, d;
    bit ok, saw;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 5 : int'($urandom_range(1, 8));
      bus.enable     = 1'b0;
      bus.pll_locked = 1'b0;
      tick();
      tick();
      bus.enable = 1'b1;
      wait_rst_fall(20, lat, ok);
      bus.pll_locked = 1'b1;
      repeat (d) tick();
      bus.pll_locked = 1'b0;
      tick();
      bus.pll_locked = 1'b1;
      wait_ready(READY_LAT + 20, lat, ok, saw);
      n_checks++;
      if (!ok || lat != READY_LAT || saw || bus.retry_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL glitch_ready[%0d]: got lat=%0d ok=%0b rst=%0b retry=%0d expected lat=%0d rst=0 retry=0",
                 it, lat, ok, saw, bus.retry_cnt, READY_LAT);
      end
    end
  endtask

  task automatic test_loss_in_run();
    bit ok;
    int first_lol = 0;
    int lol_n = 0;
    int rst_hi = 0;
    logic ready_at_lol = 1'b1;
    bring_up(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL loss_bring_up: got no ready expected ready");
    end
    bus.pll_locked = 1'b0;
    for (int k = 1; k <= LOL_LAT + RST_CYCLES + 4; k++) begin
      tick();
      if (bus.lol_pulse === 1'b1) begin
        lol_n++;
        if (first_lol == 0) begin
          first_lol    = k;
          ready_at_lol = bus.ready;
        end
      end
      if (bus.pll_rst === 1'b1) rst_hi++;
    end
    exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
    n_checks++;
    if (first_lol != LOL_LAT || lol_n != 1 || ready_at_lol !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_lol_pulse: got at=%0d count=%0d ready=%b expected at=%0d count=1 ready=0",
               first_lol, lol_n, ready_at_lol, LOL_LAT);
    end
    n_checks++;
    if (rst_hi != RST_CYCLES) begin
      n_fail++;
      $display("FAIL loss_rst_width: got %0d expected %0d", rst_hi, RST_CYCLES);
    end
    n_checks++;
    if (bus.loss_cnt !== 8'(exp_loss)) begin
      n_fail++;
      $display("FAIL loss_cnt: got %0d expected %0d", bus.loss_cnt, exp_loss);
    end
  endtask

  task automatic test_loss_saturation();
    bit ok, ok_l, ok_r, saw;
    int lat;
    logic [7:0] exp;
    bring_up(ok);
    for (int n = 0; n < 300; n++) begin
      bus.pll_locked = 1'b0;
      tick();
      if ($urandom_range(0, 1) == 1) tick();
      bus.pll_locked = 1'b1;
      wait_lol(6, ok_l);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      exp_q.push_back(8'(exp_loss));
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok_l || bus.loss_cnt !== exp) begin
        n_fail++;
        $display("FAIL loss_seq[%0d]: got loss_cnt=%0d lol_seen=%0b expected %0d", n, bus.loss_cnt, ok_l, exp);
      end
      wait_ready(READY_LAT + RST_CYCLES + 20, lat, ok_r, saw);
      if (!ok_r) begin
        n_checks++;
        n_fail++;
        $display("FAIL loss_seq_ready[%0d]: got no ready expected ready", n);
      end
    end
    n_checks++;
    if (bus.loss_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_saturate: got %0d expected 255", bus.loss_cnt);
    end
  endtask

  task automatic test_timeout();
    int widths[$];
    logic [3:0] fall_retry[$];
    int k = 0;
    int fault_at = 0;
    int width = 0;
    bit in_pulse = 1'b0;
    logic prev_rst;
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    tick();
    tick();
    bus.enable = 1'b1;
    prev_rst = 1'b1;
    while (fault_at == 0 && k < FAULT_LAT + 40) begin
      tick();
      k++;
      if (bus.fault === 1'b1) begin
        fault_at = k;
      end else begin
        if (prev_rst === 1'b1 && bus.pll_rst === 1'b0) begin
          fall_retry.push_back(bus.retry_cnt);
          if (in_pulse) widths.push_back(width);
          in_pulse = 1'b0;
        end else if (prev_rst === 1'b0 && bus.pll_rst === 1'b1) begin
          in_pulse = 1'b1;
          width = 1;
        end else if (in_pulse && bus.pll_rst === 1'b1) begin
          width++;
        end
        prev_rst = bus.pll_rst;
      end
    end
    n_checks++;
    if (fault_at != FAULT_LAT || bus.pll_rst !== 1'b1 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fault: got at=%0d pll_rst=%b ready=%b expected at=%0d pll_rst=1 ready=0",
               fault_at, bus.pll_rst, bus.ready, FAULT_LAT);
    end
    n_checks++;
    if (fall_retry.size() != MAX_RETRIES + 1) begin
      n_fail++;
      $display("FAIL timeout_attempts: got %0d expected %0d", fall_retry.size(), MAX_RETRIES + 1);
    end
    for (int i = 0; i < fall_retry.size(); i++) begin
      n_checks++;
      if (fall_retry[i] !== 4'(i)) begin
        n_fail++;
        $display("FAIL timeout_retry[%0d]: got %0d expected %0d", i, fall_retry[i], i);
      end
    end
    for (int i = 0; i < widths.size(); i++) begin
      n_checks++;
      if (widths[i] != RST_CYCLES) begin
        n_fail++;
        $display("FAIL timeout_rst_width[%0d]: got %0d expected %0d", i, widths[i], RST_CYCLES);
      end
    end
    bus.pll_locked = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (bus.fault !== 1'b1 || bus.pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: got fault=%b pll_rst=%b expected 1/1", bus.fault, bus.pll_rst);
    end
    bus.enable = 1'b0;
    tick();
    n_checks++;
    if (bus.fault !== 1'b0 || bus.pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear: got fault=%b pll_rst=%b expected 0/1", bus.fault, bus.pll_rst);
    end
    bus.pll_locked = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    bit ok;
    int lol_seen = 0;
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    tick();
    tick();
    bus.enable = 1'b1;
    wait_rst_fall(20, lat, ok);
    repeat (3) tick();
    bus.enable = 1'b0;
    tick();
    n_checks++;
    if ({bus.pll_rst, bus.ready, bus.lol_pulse} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_wait_lock: got %b expected 100", {bus.pll_rst, bus.ready, bus.lol_pulse});
    end
    bring_up(ok);
    bus.enable = 1'b0;
    tick();
    n_checks++;
    if ({bus.pll_rst, bus.ready, bus.lol_pulse, bus.fault} !== 4'b1000 || bus.loss_cnt !== 8'(exp_loss)) begin
      n_fail++;
      $display("FAIL abort_run: got %b loss=%0d expected 1000 loss=%0d",
               {bus.pll_rst, bus.ready, bus.lol_pulse, bus.fault}, bus.loss_cnt, exp_loss);
    end
    bring_up(ok);
    bus.pll_locked = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_race_pre: got ready=%b expected 1", bus.ready);
    end
    bus.enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.lol_pulse === 1'b1) lol_seen++;
    end
    n_checks++;
    if (lol_seen != 0 || bus.loss_cnt !== 8'(exp_loss) || bus.pll_rst !== 1'b1 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_race: got lol=%0d loss=%0d pll_rst=%b ready=%b expected 0 %0d 1 0",
               lol_seen, bus.loss_cnt, bus.pll_rst, bus.ready, exp_loss);
    end
  endtask

  task automatic test_async_reset();
    bit ok, saw;
    int lat;
    logic [15:0] got;
    bring_up(ok);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    got = {bus.pll_rst, bus.ready, bus.fault, bus.lol_pulse, bus.retry_cnt, bus.loss_cnt};
    n_checks++;
    if (!ok || got !== 16'h8000) begin
      n_fail++;
      $display("FAIL async_reset_run: got %h (up=%0b) expected 8000", got, ok);
    end
    exp_loss = 0;
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus.enable = 1'b1;
    wait_rst_fall(20, lat, ok);
    n_checks++;
    if (!ok || lat != EN_TO_REL) begin
      n_fail++;
      $display("FAIL post_reset_rst_len: got %0d (ok=%0b) expected %0d", lat, ok, EN_TO_REL);
    end
    bus.pll_locked = 1'b1;
    wait_ready(READY_LAT + 20, lat, ok, saw);
    n_checks++;
    if (!ok || lat != READY_LAT || bus.loss_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_ready: got lat=%0d loss=%0d expected lat=%0d loss=0", lat, bus.loss_cnt, READY_LAT);
    end
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_loss_in_run();
    test_loss_saturation();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_pll_lock_sequencer.md
AUDIO_PLL_LOCK_SEQUENCER -- requirements
Module: audio_pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16: number of cycles pll_rst is held high per reset attempt (>=1).
REQ-002 The block SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized-lock cycles required before ready asserts (>=1).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry (>=1).
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3: timeout retries permitted before FAULT (0..15).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: request to run the PLL; level-sensitive.
REQ-008 The block SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-009 The block SHALL have port pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-010 The block SHALL have port ready, output, 1 bit: audio clock stable and usable.
REQ-011 The block SHALL have port fault, output, 1 bit: retries exhausted.
REQ-012 The block SHALL have port lol_pulse, output, 1 bit: one-cycle pulse on loss of lock while ready.
REQ-013 The block SHALL have port retry_cnt, output, 4 bits: timeout retries used in the current bring-up.
REQ-014 The block SHALL have port loss_cnt, output, 8 bits: loss-of-lock events since reset, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s only, giving 2 cycles input latency.
REQ-016 States SHALL be IDLE, RESET, WAIT_LOCK, STABLE, RUN and FAULT; all outputs SHALL be registered.
REQ-017 IDLE: pll_rst=1, ready=0; enable=1 -> RESET, with the cycle counter and retry_cnt cleared.
REQ-018 RESET: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with pll_rst=0 and the cycle counter cleared.
REQ-019 WAIT_LOCK: locked_s=1 -> STABLE with the counter cleared.
REQ-020 WAIT_LOCK: the counter reaching LOCK_TIMEOUT-1 without lock -> RESET if retry_cnt<MAX_RETRIES, with retry_cnt incremented; otherwise -> FAULT.
REQ-021 STABLE: locked_s=1 for LOCK_STABLE consecutive cycles -> RUN; ready SHALL be 1 from the first RUN cycle.
REQ-022 STABLE: locked_s=0 in any cycle -> WAIT_LOCK with the counter cleared; this does not consume a retry.
REQ-023 RUN: ready=1, pll_rst=0, retry_cnt cleared on entry.
REQ-024 RUN: locked_s=0 -> lol_pulse=1 for that one cycle, loss_cnt+1 (saturating), ready=0 and -> RESET.
REQ-025 FAULT: fault=1, pll_rst=1, ready=0; the state SHALL be left only via enable=0 -> IDLE, which clears fault.
REQ-026 enable=0 in any state SHALL force IDLE on the next cycle (pll_rst=1, ready=0, lol_pulse=0); it has priority over all other transitions, and loss_cnt is retained.
REQ-027 If enable=0 and a loss of lock occur in the same cycle while in RUN, the block SHALL go to IDLE with no lol_pulse and no loss_cnt increment.
REQ-028 The cycle counter SHALL be sized to $clog2 of max(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT)+1 and SHALL never wrap within a state.

Reset
REQ-029 While reset_n=0, the block SHALL asynchronously set: state=IDLE, pll_rst=1, ready=0, fault=0, lol_pulse=0, retry_cnt=0, loss_cnt=0, counter=0, synchronizer flops=0.
REQ-030 On reset_n deassertion the block SHALL start operating on the next clk edge; reset asserted mid-operation SHALL abort immediately with no output glitch other than the reset values.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2)
REQ-031 Nominal: enable=1, pll_locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready=1 after 2 sync cycles + 8 stable cycles; retry_cnt=0.
REQ-032 Timeout: pll_locked held 0 -> 3 RESET pulses (retry_cnt 0,1,2), then fault=1 with pll_rst=1; enable=0 -> IDLE and fault=0.
REQ-033 Glitch: lock drops for 1 cycle at stable-count 5 -> return to WAIT_LOCK with retry_cnt unchanged; ready delayed a full 8 cycles after lock returns.
REQ-034 Loss in RUN: lock drops -> lol_pulse one cycle, loss_cnt=1, ready=0, new 4-cycle pll_rst; 300 losses -> loss_cnt=255.
REQ-035 Abort: enable=0 during WAIT_LOCK and during RUN -> IDLE next cycle with pll_rst=1; reset_n pulsed in RUN -> all outputs at reset values asynchronously.
